// File: rtl/fifo_read_packer.sv
// ----------------------------------------------------------------------------
// fifo_read_packer
//
// Read-side consumer of the async FIFO, living entirely in the FIFO read clock
// domain. It pops WIDTH-bit words, packs PACK of them (first popped word in
// the least significant slot) into one OW-bit word and offers that word on a
// valid/ready interface. A level-sensitive flush emits a partially filled
// word, zero-padded, once the FIFO has run dry.
//
// Parameters
//   WIDTH       FIFO word width (must match the FIFO instance)
//   PACK        FIFO words per output word (>= 2); OW = WIDTH*PACK
//
// Ports
//   clk_in      in   1        read-domain clock (FIFO r_clk)
//   rst_n       in   1        asynchronous active-low reset
//   fifo_empty  in   1        FIFO empty flag
//   fifo_rdata  in   WIDTH    FIFO read data, valid one cycle after a pop
//   fifo_rd_rq  out  1        pop request to the FIFO (combinational)
//   out_data    out  OW       packed word, slot k in bits [k*WIDTH +: WIDTH]
//   out_words   out  CW       number of valid FIFO words in out_data
//   out_valid   out  1        out_data/out_words valid
//   out_parity  out  1        ^out_data (only with PACKER_PARITY_EN)
//   out_ready   in   1        downstream accept
//   flush       in   1        emit the partial word once the FIFO is empty
//
// Build option
//   PACKER_PARITY_EN  adds out_parity, registered alongside out_data.
// ----------------------------------------------------------------------------
module fifo_read_packer #(
    parameter int WIDTH = 4,
    parameter int PACK  = 2,
    localparam int OW   = WIDTH * PACK,
    localparam int CW   = $clog2(PACK + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_rq,
    output logic [OW-1:0]    out_data,
    output logic [CW-1:0]    out_words,
    output logic             out_valid,
`ifdef PACKER_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready,
    input  logic             flush
);

    localparam logic [CW-1:0] PACK_C = CW'(PACK);

    // cnt counts captured words plus the pop still in flight.
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inflight_q;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_words_q, out_words_d;
    logic          out_valid_q, out_valid_d;
`ifdef PACKER_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic          pop;
    logic          slot_free;
    logic          full_xfer;
    logic          flush_xfer;
    logic          xfer;
    logic [CW-1:0] slot;

    // NOTE: every signal gets its default at the top of the block so that no
    // path leaves it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        // Gated by rst_n so the request is low for the whole reset window,
        // not only after the first edge.
        pop        = rst_n & ~fifo_empty & (cnt_q < PACK_C);
        slot_free  = ~out_valid_q | out_ready;
        full_xfer  = (cnt_q == PACK_C) & ~inflight_q & slot_free;
        // fifo_empty is required, so a pop on the same edge always wins.
        flush_xfer = flush & fifo_empty & (cnt_q != '0) & (cnt_q < PACK_C)
                   & ~inflight_q & slot_free;
        xfer       = full_xfer | flush_xfer;

        // Slot for the word landing now = words already captured.
        slot  = cnt_q - CW'(inflight_q);
        acc_d = acc_q;
        if (inflight_q) begin
            acc_d[int'(slot)*WIDTH +: WIDTH] = fifo_rdata;
        end

        // A transfer never coincides with a pop or a capture: it needs an
        // empty pipe and either a full count or an empty FIFO.
        cnt_d = cnt_q + CW'(pop);
        if (xfer) begin
            cnt_d = '0;
            acc_d = '0;
        end

        out_data_d  = out_data_q;
        out_words_d = out_words_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = acc_q;
            out_words_d = cnt_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef PACKER_PARITY_EN
        parity_d = xfer ? ^acc_q : parity_q;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_words_q <= '0;
            out_valid_q <= 1'b0;
`ifdef PACKER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            inflight_q  <= pop;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_words_q <= out_words_d;
            out_valid_q <= out_valid_d;
`ifdef PACKER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign fifo_rd_rq = pop;
    assign out_data   = out_data_q;
    assign out_words  = out_words_q;
    assign out_valid  = out_valid_q;
`ifdef PACKER_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule
